proj_gfm_collector: RTL and testbench
=====================================

# proj_gfm_collector

Downstream neighbour of the fragment extender. Consumes the extender's stream of one-hot fragment parts (one part per cycle) plus the signed fragment start index, and reassembles each full one-hot fragment. Clips fragment bases that fall before reference position 0. Presents completed fragments through a 2-entry output buffer with a valid/ready handshake to the GFM memory writer.

## Interface
- FRAG_LEN, 64: bases per fragment.
- PART_BASES, 16: bases per incoming part; FRAG_LEN % PART_BASES == 0.
- ONE_HOT_LEN, 4: bits per one-hot base.
- SIGNED_INDICE_LEN, 17: width of the signed start index (two's complement).
- Derived: PARTS = FRAG_LEN/PART_BASES; PART_W = PART_BASES*ONE_HOT_LEN; CLIP_W = $clog2(FRAG_LEN+1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_index/in_gfm valid this cycle; upstream cannot stall.
- in_index  in  SIGNED_INDICE_LEN  signed fragment start index; sampled only on part 0.
- in_gfm  in  PART_W  one-hot part; base i in bits [i*4 +: 4].
- out_valid  out  1  buffer head holds a complete fragment.
- out_ready  in  1  consumer accepts the head when out_valid is high.
- out_start_index  out  SIGNED_INDICE_LEN-1  unsigned, clamped start position.
- out_gfm  out  FRAG_LEN*ONE_HOT_LEN  assembled fragment; part p in bits [p*PART_W +: PART_W].
- out_clip  out  CLIP_W  number of leading bases zeroed by clipping.
- overflow  out  1  sticky: a completed fragment was dropped.

## Operation
- Part counter part_idx, range 0..PARTS-1. It advances only on in_valid and wraps from PARTS-1 to 0. When in_valid is low, it and the partial assembly hold.
- On in_valid with part_idx==0: capture in_index into idx_reg.
- On every in_valid: write in_gfm into assembly slot part_idx.
- On in_valid with part_idx==PARTS-1, the fragment is complete. Form the push entry from the assembly, with the current in_gfm as the last part:
  - If idx_reg >= 0: out_start_index = idx_reg[SIGNED_INDICE_LEN-2:0], clip = 0.
  - If idx_reg < 0: clip = min(-idx_reg, FRAG_LEN). Bases 0..clip-1 are forced to 4'b0000 and out_start_index = 0.
- Output buffer: 2-entry FIFO (read/write pointers plus count).
  - Pop when out_valid && out_ready.
  - Push when the fragment completes.
  - On a push with count==2 and no pop in the same cycle, the entry is dropped and overflow is set. overflow clears only on reset.
  - Push and pop in the same cycle are both performed, including when full; count is unchanged.
- out_* signals show the FIFO head and are registered. While out_valid is high and out_ready is low, they hold stable.
- Assembly bases beyond the clip are never modified by clipping. Incoming one-hot values are passed through unchecked, including 4'b0000.

## Timing
- Reset values: out_valid=0, out_start_index=0, out_gfm=0, out_clip=0, overflow=0, part_idx=0, FIFO count=0, pointers=0.
- Latency: if the last part is accepted at edge N and the FIFO was empty, out_valid is high after edge N.
- Throughput: one fragment per PARTS valid cycles. The consumer must sustain one pop per PARTS cycles on average; the 2 entries absorb bursts.
- Reset mid-fragment or mid-handshake: all state is discarded asynchronously. The partial fragment is lost and the first in_valid after reset is treated as part 0.
- Clip arithmetic: negate in SIGNED_INDICE_LEN bits, compare against FRAG_LEN, saturate to FRAG_LEN. The most negative index gives clip = FRAG_LEN.

## Test plan
- Four consecutive valid parts of 16×4'b0001, 16×4'b0010, 16×4'b0100, 16×4'b1000, with index 10 and out_ready=1.
  - Expect out_valid exactly one cycle after the 4th part.
  - Expect out_start_index=10, out_clip=0, and the parts in ascending bit order.
- Index -5, all parts 4'b1000 -> out_start_index=0, out_clip=5, bases 0-4 = 4'b0000, bases 5-63 = 4'b1000.
- Index -100 -> out_clip=64, out_gfm all zero, out_start_index=0.
- out_ready=0 across three complete fragments (indices 1, 2, 3):
  - Expect fragments 1 and 2 buffered and fragment 3 dropped.
  - Expect overflow=1 sticky.
  - Raising out_ready then yields indices 1 and 2 only.
- Buffer full with pop and push in the same cycle -> no overflow; pop order is preserved.
- in_valid deasserted for 3 cycles after part 1, then reset asserted after part 2.
  - During the gap, part_idx holds.
  - After reset, all outputs are 0 and the next fragment assembles from part 0 with its own index.

Source files
------------

// File: rtl/proj_gfm_collector.sv
// proj_gfm_collector: rebuilds one-hot fragments from their parts, clips
// bases that fall before position 0, and queues results in a 2-entry FIFO.
module proj_gfm_collector #(
    parameter int FRAG_LEN          = 64,
    parameter int PART_BASES        = 16,
    parameter int ONE_HOT_LEN       = 4,
    parameter int SIGNED_INDICE_LEN = 17,
    localparam int PARTS  = FRAG_LEN / PART_BASES,
    localparam int PART_W = PART_BASES * ONE_HOT_LEN,
    localparam int CLIP_W = $clog2(FRAG_LEN + 1),
    localparam int GFM_W  = FRAG_LEN * ONE_HOT_LEN,
    localparam int IDX_W  = SIGNED_INDICE_LEN - 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [SIGNED_INDICE_LEN-1:0] in_index,
    input  logic [PART_W-1:0]            in_gfm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IDX_W-1:0]             out_start_index,
    output logic [GFM_W-1:0]             out_gfm,
    output logic [CLIP_W-1:0]            out_clip,
    output logic                         overflow
);

    localparam int PI_W = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam logic [PI_W-1:0] LAST = PI_W'(PARTS - 1);

    logic [PI_W-1:0]              part_idx;
    logic [SIGNED_INDICE_LEN-1:0] idx_reg;
    logic [PART_W-1:0]            asm_q [PARTS];

    logic [IDX_W-1:0]  mem_idx  [2];
    logic [GFM_W-1:0]  mem_gfm  [2];
    logic [CLIP_W-1:0] mem_clip [2];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic [SIGNED_INDICE_LEN-1:0] idx_use;
    logic [SIGNED_INDICE_LEN-1:0] neg;
    logic [GFM_W-1:0]             frag;
    logic [GFM_W-1:0]             push_gfm;
    logic [CLIP_W-1:0]            push_clip;
    logic [IDX_W-1:0]             push_idx;

    logic              push;
    logic              pop;
    logic              do_write;
    logic              rd_nx;
    logic              wr_nx;
    logic [1:0]        count_nx;
    logic [IDX_W-1:0]  head_idx;
    logic [GFM_W-1:0]  head_gfm;
    logic [CLIP_W-1:0] head_clip;

    // Fragment view with the part arriving this cycle merged in.
    always_comb begin
        idx_use = (part_idx == '0) ? in_index : idx_reg;
        neg     = '0 - idx_use;
        for (int p = 0; p < PARTS; p++) begin
            frag[p*PART_W +: PART_W] =
                (PI_W'(p) == part_idx) ? in_gfm : asm_q[p];
        end
        push_idx  = '0;
        push_clip = '0;
        if (idx_use[SIGNED_INDICE_LEN-1]) begin
            if (neg >= SIGNED_INDICE_LEN'(FRAG_LEN))
                push_clip = CLIP_W'(FRAG_LEN);
            else
                push_clip = neg[CLIP_W-1:0];
        end else begin
            push_idx = idx_use[IDX_W-1:0];
        end
        push_gfm = frag;
        for (int b = 0; b < FRAG_LEN; b++) begin
            if (CLIP_W'(b) < push_clip)
                push_gfm[b*ONE_HOT_LEN +: ONE_HOT_LEN] = '0;
        end
    end

    // Output regs are loaded with the next head so a push into an
    // empty buffer is visible right after the completing edge.
    always_comb begin
        push     = in_valid && (part_idx == LAST);
        pop      = out_valid && out_ready;
        do_write = push && ((count != 2'd2) || pop);
        rd_nx    = rd_ptr ^ pop;
        wr_nx    = wr_ptr ^ do_write;
        unique case ({do_write, pop})
            2'b10:   count_nx = count + 2'd1;
            2'b01:   count_nx = count - 2'd1;
            default: count_nx = count;
        endcase
        if (do_write && (wr_ptr == rd_nx)) begin
            head_idx  = push_idx;
            head_gfm  = push_gfm;
            head_clip = push_clip;
        end else begin
            head_idx  = mem_idx[rd_nx];
            head_gfm  = mem_gfm[rd_nx];
            head_clip = mem_clip[rd_nx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            part_idx        <= '0;
            idx_reg         <= '0;
            for (int p = 0; p < PARTS; p++) asm_q[p] <= '0;
            for (int e = 0; e < 2; e++) begin
                mem_idx[e]  <= '0;
                mem_gfm[e]  <= '0;
                mem_clip[e] <= '0;
            end
            rd_ptr          <= 1'b0;
            wr_ptr          <= 1'b0;
            count           <= '0;
            overflow        <= 1'b0;
            out_valid       <= 1'b0;
            out_start_index <= '0;
            out_gfm         <= '0;
            out_clip        <= '0;
        end else begin
            if (in_valid) begin
                part_idx <= (part_idx == LAST) ? '0 : part_idx + 1'b1;
                asm_q[part_idx] <= in_gfm;
                if (part_idx == '0) idx_reg <= in_index;
            end
            if (do_write) begin
                mem_idx[wr_ptr]  <= push_idx;
                mem_gfm[wr_ptr]  <= push_gfm;
                mem_clip[wr_ptr] <= push_clip;
            end
            if (push && !do_write) overflow <= 1'b1;
            rd_ptr          <= rd_nx;
            wr_ptr          <= wr_nx;
            count           <= count_nx;
            out_valid       <= (count_nx != 2'd0);
            out_start_index <= head_idx;
            out_gfm         <= head_gfm;
            out_clip        <= head_clip;
        end
    end

endmodule

// File: tb/tb_proj_gfm_collector.sv
// Directed bench for proj_gfm_collector: assembly, clipping, buffering,
// overflow and reset recovery.
module tb_proj_gfm_collector;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [16:0]   in_index;
    logic [63:0]   in_gfm;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_start_index;
    logic [255:0]  out_gfm;
    logic [6:0]    out_clip;
    logic          overflow;

    int checks;
    int errors;

    proj_gfm_collector dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_index        (in_index),
        .in_gfm          (in_gfm),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_start_index (out_start_index),
        .out_gfm         (out_gfm),
        .out_clip        (out_clip),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] fill(input logic [3:0] nib);
        return {16{nib}};
    endfunction

    // Inputs change at the falling edge; outputs are read there too.
    task automatic drive(input logic v, input logic [16:0] idx,
                         input logic [63:0] g);
        in_valid = v;
        in_index = idx;
        in_gfm   = g;
        @(negedge clk);
    endtask

    task automatic send_frag(input logic [16:0] idx, input logic [63:0] g0,
                             input logic [63:0] g1, input logic [63:0] g2,
                             input logic [63:0] g3);
        drive(1'b1, idx, g0);
        drive(1'b1, 17'h1abcd, g1);
        drive(1'b1, 17'h1abcd, g2);
        drive(1'b1, 17'h1abcd, g3);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        #3;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_start_index, out_gfm, out_clip, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b idx=%0d clip=%0d ovf=%b gfm=%h want all 0",
                     out_valid, out_start_index, out_clip, overflow, out_gfm);
        end
    endtask

    task automatic test_basic();
        logic [255:0] exp;
        exp = {fill(4'h8), fill(4'h4), fill(4'h2), fill(4'h1)};
        out_ready = 1'b1;
        drive(1'b1, 17'd10, fill(4'h1));
        drive(1'b1, 17'd0, fill(4'h2));
        drive(1'b1, 17'd0, fill(4'h4));
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid got %b want 0", out_valid);
        end
        drive(1'b1, 17'd0, fill(4'h8));
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got %b want 1", out_valid);
        end
        checks++;
        if (out_start_index !== 16'd10 || out_clip !== 7'd0) begin
            errors++;
            $display("FAIL basic_idx_clip got idx=%0d clip=%0d want 10 0",
                     out_start_index, out_clip);
        end
        checks++;
        if (out_gfm !== exp) begin
            errors++;
            $display("FAIL basic_gfm got %h want %h", out_gfm, exp);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_clip();
        logic [255:0] exp;
        exp = {{59{4'h8}}, 20'h0};
        out_ready = 1'b0;
        send_frag(-17'sd5, fill(4'h8), fill(4'h8), fill(4'h8), fill(4'h8));
        checks++;
        if (out_valid !== 1'b1 || out_start_index !== 16'd0 || out_clip !== 7'd5) begin
            errors++;
            $display("FAIL clip5_meta got v=%b idx=%0d clip=%0d want 1 0 5",
                     out_valid, out_start_index, out_clip);
        end
        checks++;
        if (out_gfm !== exp) begin
            errors++;
            $display("FAIL clip5_gfm got %h want %h", out_gfm, exp);
        end
        drain();
        send_frag(-17'sd100, fill(4'h1), fill(4'h2), fill(4'h4), fill(4'h8));
        checks++;
        if (out_valid !== 1'b1 || out_start_index !== 16'd0 ||
            out_clip !== 7'd64 || out_gfm !== '0) begin
            errors++;
            $display("FAIL clip100 got v=%b idx=%0d clip=%0d gfm=%h want 1 0 64 0",
                     out_valid, out_start_index, out_clip, out_gfm);
        end
        drain();
        send_frag(17'h10000, fill(4'h2), fill(4'h2), fill(4'h2), fill(4'h2));
        checks++;
        if (out_valid !== 1'b1 || out_clip !== 7'd64 || out_gfm !== '0) begin
            errors++;
            $display("FAIL clip_minneg got v=%b clip=%0d gfm=%h want 1 64 0",
                     out_valid, out_clip, out_gfm);
        end
        drain();
        send_frag(17'h0ffff, fill(4'h4), fill(4'h4), fill(4'h4), fill(4'h4));
        checks++;
        if (out_start_index !== 16'hffff || out_clip !== 7'd0 ||
            out_gfm !== {4{fill(4'h4)}}) begin
            errors++;
            $display("FAIL max_pos got idx=%h clip=%0d want ffff 0",
                     out_start_index, out_clip);
        end
        drain();
    endtask

    task automatic test_overflow();
        out_ready = 1'b0;
        send_frag(17'd1, fill(4'h1), fill(4'h1), fill(4'h1), fill(4'h1));
        send_frag(17'd2, fill(4'h2), fill(4'h2), fill(4'h2), fill(4'h2));
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_early got %b want 0", overflow);
        end
        send_frag(17'd3, fill(4'h4), fill(4'h4), fill(4'h4), fill(4'h4));
        checks++;
        if (overflow !== 1'b1 || out_valid !== 1'b1 || out_start_index !== 16'd1) begin
            errors++;
            $display("FAIL ovf_set got ovf=%b v=%b idx=%0d want 1 1 1",
                     overflow, out_valid, out_start_index);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_start_index !== 16'd2 ||
            out_gfm !== {4{fill(4'h2)}}) begin
            errors++;
            $display("FAIL ovf_second got v=%b idx=%0d want 1 2",
                     out_valid, out_start_index);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drained got v=%b ovf=%b want 0 1", out_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        out_ready = 1'b0;
        send_frag(17'd20, fill(4'h1), fill(4'h1), fill(4'h1), fill(4'h1));
        send_frag(17'd21, fill(4'h2), fill(4'h2), fill(4'h2), fill(4'h2));
        drive(1'b1, 17'd22, fill(4'h4));
        drive(1'b1, 17'd0, fill(4'h4));
        drive(1'b1, 17'd0, fill(4'h4));
        checks++;
        if (out_start_index !== 16'd20 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL b2b_hold got v=%b idx=%0d want 1 20",
                     out_valid, out_start_index);
        end
        out_ready = 1'b1;
        drive(1'b1, 17'd0, fill(4'h4));
        in_valid = 1'b0;
        checks++;
        if (overflow !== 1'b0 || out_valid !== 1'b1 || out_start_index !== 16'd21) begin
            errors++;
            $display("FAIL b2b_swap got ovf=%b v=%b idx=%0d want 0 1 21",
                     overflow, out_valid, out_start_index);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_start_index !== 16'd22 ||
            out_gfm !== {4{fill(4'h4)}}) begin
            errors++;
            $display("FAIL b2b_third got v=%b idx=%0d want 1 22",
                     out_valid, out_start_index);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_empty got v=%b ovf=%b want 0 0", out_valid, overflow);
        end
    endtask

    task automatic test_gap_reset();
        logic [255:0] exp;
        exp = {fill(4'h1), fill(4'h2), fill(4'h4), fill(4'h8)};
        do_reset();
        out_ready = 1'b1;
        drive(1'b1, 17'd7, fill(4'h1));
        drive(1'b1, 17'd0, fill(4'h1));
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 17'd99, fill(4'hf));
            checks++;
            if (dut.part_idx !== 2'd2) begin
                errors++;
                $display("FAIL gap_hold_%0d got part_idx=%0d want 2", i, dut.part_idx);
            end
        end
        drive(1'b1, 17'd0, fill(4'h1));
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_start_index, out_gfm, out_clip, overflow} !== '0 ||
            dut.part_idx !== 2'd0) begin
            errors++;
            $display("FAIL midreset got v=%b idx=%0d clip=%0d part_idx=%0d want 0",
                     out_valid, out_start_index, out_clip, dut.part_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_frag(17'd33, fill(4'h8), fill(4'h4), fill(4'h2), fill(4'h1));
        checks++;
        if (out_valid !== 1'b1 || out_start_index !== 16'd33 ||
            out_clip !== 7'd0 || out_gfm !== exp) begin
            errors++;
            $display("FAIL post_reset got v=%b idx=%0d clip=%0d gfm=%h want 1 33 0 %h",
                     out_valid, out_start_index, out_clip, out_gfm, exp);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_gfm    = '0;
        out_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_clip();
        test_overflow();
        test_back_to_back();
        test_gap_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
